// File: rtl/rgb_fader.sv
// rgb_fader: steps a registered RGB colour one LSB per channel toward an
// accepted target colour at a fixed tick rate, for a downstream WS2812 driver.
//
// Parameters:
//   CLK_FREQ  i_clk frequency in Hz
//   STEP_HZ   fade step rate in Hz (1 <= STEP_HZ <= CLK_FREQ)
// Ports:
//   i_clk                      single rising-edge clock
//   i_rst_n                    asynchronous active-low reset
//   i_valid / o_ready          target handshake (accept when both high)
//   i_red, i_green, i_blue     target colour, sampled on accept
//   i_blank                    force colour outputs to zero (fade continues)
//   o_red, o_green, o_blue     registered colour outputs
//   o_busy                     fade in progress
//   o_done                     one-cycle pulse when a fade (or no-op accept) completes
module rgb_fader #(
    parameter int unsigned CLK_FREQ = 16000000,
    parameter int unsigned STEP_HZ  = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_red,
    input  logic [7:0] i_green,
    input  logic [7:0] i_blue,
    input  logic       i_blank,
    output logic [7:0] o_red,
    output logic [7:0] o_green,
    output logic [7:0] o_blue,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned TICK_RAW = CLK_FREQ / STEP_HZ;
    localparam int unsigned TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic {
        IDLE,
        FADE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic             tick;

    logic [7:0] cur_r, cur_g, cur_b;
    logic [7:0] tgt_r, tgt_g, tgt_b;
    logic [7:0] step_r, step_g, step_b;

    logic accept;
    logic same;
    logic fade_end;

    // One LSB toward the target; saturation is implicit since the step
    // never passes the target value.
    function automatic logic [7:0] toward(input logic [7:0] c, input logic [7:0] t);
        if (c < t) begin
            return c + 8'd1;
        end else if (c > t) begin
            return c - 8'd1;
        end else begin
            return c;
        end
    endfunction

    // Free-running tick divider, restarts from 0 on reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

    always_comb begin
        accept   = i_valid && (state == IDLE);
        same     = ({i_red, i_green, i_blue} == {cur_r, cur_g, cur_b});
        step_r   = toward(cur_r, tgt_r);
        step_g   = toward(cur_g, tgt_g);
        step_b   = toward(cur_b, tgt_b);
        // Completion is judged on the post-step colour so IDLE is entered
        // on the same tick that lands on the target.
        fade_end = (state == FADE) && tick &&
                   ({step_r, step_g, step_b} == {tgt_r, tgt_g, tgt_b});
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && !same) state_next = FADE;
            FADE: if (fade_end)        state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_ready = (state == IDLE);
        o_busy  = (state == FADE);
    end

    // Colour datapath, done pulse and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cur_r   <= '0;
            cur_g   <= '0;
            cur_b   <= '0;
            tgt_r   <= '0;
            tgt_g   <= '0;
            tgt_b   <= '0;
            o_done  <= 1'b0;
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
        end else begin
            if (accept) begin
                tgt_r <= i_red;
                tgt_g <= i_green;
                tgt_b <= i_blue;
            end
            if ((state == FADE) && tick) begin
                cur_r <= step_r;
                cur_g <= step_g;
                cur_b <= step_b;
            end
            o_done  <= (accept && same) || fade_end;
            o_red   <= i_blank ? '0 : cur_r;
            o_green <= i_blank ? '0 : cur_g;
            o_blue  <= i_blank ? '0 : cur_b;
        end
    end

endmodule

// File: tb/tb_rgb_fader.sv
// tb_rgb_fader: directed, table-driven bench for rgb_fader with
// CLK_FREQ=16, STEP_HZ=4 (one tick every 4 clocks).
// Ports: none (top-level bench).
module tb_rgb_fader;

    localparam int TDIV = 4;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic       ready;
    logic [7:0] red, green, blue;
    logic       blank;
    logic [7:0] o_red, o_green, o_blue;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;
    int k;          // index of the last clock edge since reset release

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         ticks;
        string      name;
    } vec_t;

    vec_t vecs[8];

    rgb_fader #(
        .CLK_FREQ(16),
        .STEP_HZ (4)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_valid(valid),
        .o_ready(ready),
        .i_red  (red),
        .i_green(green),
        .i_blue (blue),
        .i_blank(blank),
        .o_red  (o_red),
        .o_green(o_green),
        .o_blue (o_blue),
        .o_busy (busy),
        .o_done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        k++;
    endtask

    function automatic logic [23:0] outs();
        return {o_red, o_green, o_blue};
    endfunction

    function automatic bit near(input logic [23:0] a, input logic [23:0] b);
        for (int i = 0; i < 3; i++) begin
            int d;
            d = int'(a[i*8 +: 8]) - int'(b[i*8 +: 8]);
            if (d > 1 || d < -1) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Edge at which o_done must appear: ticks fall on edges k with k%4 == 3.
    function automatic int done_edge(input int ka, input int t);
        int k1;
        if (t == 0) return ka;
        k1 = ka + 1;
        while (k1 % TDIV != TDIV - 1) k1++;
        return k1 + TDIV * (t - 1);
    endfunction

    task automatic do_accept(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             output int ka, input string nm);
        logic rdy;
        int   guard;
        red   = r;
        green = g;
        blue  = b;
        valid = 1'b1;
        guard = 0;
        rdy   = 1'b0;
        while (!rdy && guard < 2000) begin
            rdy = ready;
            step;
            guard++;
        end
        valid = 1'b0;
        ka = k;
        chk({nm, "_accept"}, 32'(rdy), 32'd1);
    endtask

    // Runs from the accept sample until the sample after o_done.
    task automatic watch_fade(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input int t, input int ka, input int blank_at, input string nm);
        int          kd, off, bad_done, bad_busy, bad_step, bad_blank;
        logic [23:0] prev, v;
        kd = done_edge(ka, t);
        off = 0;
        bad_done = 0;
        bad_busy = 0;
        bad_step = 0;
        bad_blank = 0;
        prev = outs();
        v = prev;
        forever begin
            if (done !== (k == kd)) bad_done++;
            if (k <= kd && busy !== (t != 0 && k < kd)) bad_busy++;
            if (k > kd) break;
            if (blank_at > 0 && off == blank_at) begin
                v = outs();
                blank = 1'b1;
            end
            if (blank_at > 0 && off == blank_at + 7) blank = 1'b0;
            step;
            off++;
            if (blank_at > 0 && off > blank_at && off <= blank_at + 7) begin
                if (outs() !== 24'h0) bad_blank++;
            end else if (blank_at > 0 && off == blank_at + 8) begin
                // 8 edges elapsed while blanked: exactly two ticks
                chk({nm, "_after_blank"}, 32'(outs()), 32'(v + 24'h020202));
            end else if (!near(prev, outs())) begin
                bad_step++;
            end
            prev = outs();
        end
        chk({nm, "_busy"}, 32'(bad_busy), 32'd0);
        chk({nm, "_done_timing"}, 32'(bad_done), 32'd0);
        chk({nm, "_step_size"}, 32'(bad_step), 32'd0);
        if (blank_at > 0) chk({nm, "_blank_zero"}, 32'(bad_blank), 32'd0);
        chk({nm, "_final"}, 32'(outs()), 32'({r, g, b}));
    endtask

    initial begin
        int ka;
        int guard;
        int bad;

        vecs[0] = '{8'h0F, 8'h00, 8'h0F, 15,  "s1_rise"};
        vecs[1] = '{8'h0F, 8'h0F, 8'h00, 15,  "cross"};
        vecs[2] = '{8'h00, 8'h0F, 8'h0F, 15,  "s2_swap"};
        vecs[3] = '{8'h00, 8'h0F, 8'h0F, 0,   "s3_equal"};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 255, "to_max"};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFF, 0,   "equal_max"};
        vecs[6] = '{8'h00, 8'h00, 8'h00, 255, "to_zero"};
        vecs[7] = '{8'h03, 8'h01, 8'h02, 3,   "small"};

        rst_n = 1'b1;
        valid = 1'b0;
        blank = 1'b0;
        red   = '0;
        green = '0;
        blue  = '0;
        k     = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_outs",  32'(outs()), 32'h0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        step;
        step;
        rst_n = 1'b1;
        k = -1;

        for (int i = 0; i < 8; i++) begin
            do_accept(vecs[i].r, vecs[i].g, vecs[i].b, ka, vecs[i].name);
            watch_fade(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].ticks, ka, 0, vecs[i].name);
            chk({vecs[i].name, "_ready"}, 32'(ready), 32'd1);
        end

        // Held request during a fade is ignored, then taken right after done.
        do_accept(8'h10, 8'h10, 8'h10, ka, "s4_a");
        red   = 8'h12;
        green = 8'h10;
        blue  = 8'h0E;
        valid = 1'b1;
        watch_fade(8'h10, 8'h10, 8'h10, 15, ka, 0, "s4_a");
        chk("s4_held_accept", 32'(busy), 32'd1);
        valid = 1'b0;
        watch_fade(8'h12, 8'h10, 8'h0E, 2, k, 0, "s4_b");

        // Blank mid-fade: outputs zero, fade continues, done timing intact.
        do_accept(8'h40, 8'h40, 8'h40, ka, "s5");
        watch_fade(8'h40, 8'h40, 8'h40, 50, ka, 20, "s5");

        // Reset mid-fade abandons the fade.
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step;
        k = -1;
        do_accept(8'h10, 8'h10, 8'h10, ka, "s6");
        guard = 0;
        while (o_red !== 8'h07 && guard < 200) begin
            step;
            guard++;
        end
        chk("s6_reach7", 32'(o_red), 32'h07);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_outs",  32'(outs()), 32'h0);
        chk("s6_rst_ready", 32'(ready), 32'd1);
        chk("s6_rst_busy",  32'(busy), 32'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step;
            if (done !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        k = -1;
        for (int i = 0; i < 6; i++) begin
            step;
            if (done !== 1'b0) bad++;
        end
        chk("s6_no_done", 32'(bad), 32'd0);
        do_accept(8'h02, 8'h00, 8'h01, ka, "s6_restart");
        watch_fade(8'h02, 8'h00, 8'h01, 2, ka, 0, "s6_restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
